// File: rtl/hyperbus_pkg.sv
// Shared types and helpers for the hyperbus PHY clock divider.
package hyperbus_pkg;

  localparam int unsigned MinDiv = 2;

  typedef struct packed {
    logic restart;
    logic stop;
  } div_ctrl_t;

  function automatic logic [31:0] clamp_div(logic [31:0] x);
    return (x < MinDiv) ? 32'(MinDiv) : x;
  endfunction

endpackage

// File: rtl/hyperbus_clk_div_core.sv
// Period counter, posedge/negedge phase flops and odd/even combine.
module hyperbus_clk_div_core
  import hyperbus_pkg::*;
#(
  parameter int unsigned DivWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [DivWidth-1:0] div_i,
  input  div_ctrl_t           ctrl_i,
  output logic                wrap_o,
  output logic                idle_o,
  output logic                clk_o
);

  logic [DivWidth-1:0] cnt_q, cnt_d, cnt_inc, half;
  logic r_clk, r_clk_d, r_clk_n;

  assign half    = div_i >> 1;
  assign cnt_inc = cnt_q + DivWidth'(1);
  // Parked state: counter at zero with the output low.
  assign idle_o  = (cnt_q == '0) && !r_clk;
  assign wrap_o  = !idle_o &&
                   (cnt_q == div_i - DivWidth'(1));

  always_comb begin
    cnt_d   = cnt_q;
    r_clk_d = r_clk;
    if (ctrl_i.restart) begin
      cnt_d   = '0;
      r_clk_d = 1'b1;
    end else if (ctrl_i.stop) begin
      cnt_d   = '0;
      r_clk_d = 1'b0;
    end else if (!idle_o) begin
      cnt_d   = cnt_inc;
      r_clk_d = (cnt_inc < half);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      r_clk <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      r_clk <= r_clk_d;
    end
  end

  // Half-cycle stretch only for odd ratios.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_clk_n <= 1'b0;
    else         r_clk_n <= r_clk & div_i[0];
  end

  tc_clk_or2 i_or (
    .clk0_i (r_clk),
    .clk1_i (r_clk_n),
    .clk_o  (clk_o)
  );

endmodule

// File: rtl/tc_clk.sv
// Clock-path cells: OR combine and 2:1 clock multiplexer.
module tc_clk_or2 (
  input  logic clk0_i,
  input  logic clk1_i,
  output logic clk_o
);
  assign clk_o = clk0_i | clk1_i;
endmodule

module tc_clk_mux2 (
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic clk_sel_i,
  output logic clk_o
);
  assign clk_o = clk_sel_i ? clk1_i : clk0_i;
endmodule

// File: rtl/hyperbus_clk_div.sv
// Programmable PHY clock divider with handshaked ratio updates.
module hyperbus_clk_div
  import hyperbus_pkg::*;
#(
  parameter int unsigned DivWidth   = 8,
  parameter int unsigned DefaultDiv = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                test_mode_i,
  input  logic                en_i,
  input  logic [DivWidth-1:0] div_i,
  input  logic                div_valid_i,
  output logic                div_ready_o,
  output logic                clk_o
);

  localparam logic [DivWidth-1:0] RstDiv =
    DivWidth'(clamp_div(32'(DefaultDiv)));

  logic [DivWidth-1:0] div_q, div_pend_q;
  logic pend_q, accept, bound;
  logic wrap, idle, clk_div;
  div_ctrl_t ctrl;

  assign div_ready_o  = ~pend_q;
  assign accept       = div_valid_i & ~pend_q;
  // Period boundary: the wrap edge, or any edge while parked.
  assign bound        = wrap | idle;
  assign ctrl.restart = bound & en_i;
  assign ctrl.stop    = bound & ~en_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q      <= RstDiv;
      div_pend_q <= RstDiv;
      pend_q     <= 1'b0;
    end else if (bound && pend_q) begin
      div_q      <= div_pend_q;
      pend_q     <= 1'b0;
    end else if (accept) begin
      div_pend_q <= DivWidth'(clamp_div(32'(div_i)));
      pend_q     <= 1'b1;
    end
  end

  hyperbus_clk_div_core #(
    .DivWidth (DivWidth)
  ) i_core (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .div_i  (div_q),
    .ctrl_i (ctrl),
    .wrap_o (wrap),
    .idle_o (idle),
    .clk_o  (clk_div)
  );

  tc_clk_mux2 i_bypass (
    .clk0_i    (clk_div),
    .clk1_i    (clk_i),
    .clk_sel_i (test_mode_i),
    .clk_o     (clk_o)
  );

endmodule

// File: tb/tb_hyperbus_clk_div.sv
// Self-checking bench for hyperbus_clk_div.
module tb_hyperbus_clk_div;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic test_mode = 1'b0;
  logic en = 1'b0;
  logic div_valid = 1'b0;
  logic [W-1:0] div = '0;
  logic div_ready;
  logic clk_o;

  int n_vec = 0;
  int n_err = 0;

  hyperbus_clk_div #(
    .DivWidth   (W),
    .DefaultDiv (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .test_mode_i (test_mode),
    .en_i        (en),
    .div_i       (div),
    .div_valid_i (div_valid),
    .div_ready_o (div_ready),
    .clk_o       (clk_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Waveform model: a period is 2N half-cycles, high for the first N.
  bit m_run;
  bit m_pend;
  int m_n, m_k, m_pn;

  task automatic m_reset();
    m_run = 0; m_k = 0; m_n = 4;
    m_pend = 0; m_pn = 0;
  endtask

  task automatic m_edge(bit e, bit v, int d);
    bit was_pend;
    was_pend = m_pend;
    if (m_run && m_k < m_n - 1) begin
      m_k++;
    end else begin
      if (was_pend) begin
        m_n = m_pn;
        m_pend = 0;
      end
      m_run = e;
      m_k = 0;
    end
    if (!was_pend && v) begin
      m_pn = (d < 2) ? 2 : d;
      m_pend = 1;
    end
  endtask

  function automatic bit m_clk(int second);
    return m_run && (2 * m_k + second < m_n);
  endfunction

  task automatic chk(string nm, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step(bit e, bit v, int d, string nm);
    en = e; div_valid = v; div = W'(d);
    @(posedge clk);
    m_edge(e, v, d);
    #1;
    chk({nm, ".hi"}, clk_o, m_clk(0));
    chk({nm, ".rdy"}, div_ready, !m_pend);
    @(negedge clk);
    #1;
    chk({nm, ".lo"}, clk_o, m_clk(1));
  endtask

  typedef struct {
    bit e; bit v; int d;
    bit hi; bit lo; bit rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(bit e, bit v, int d,
                     bit hi, bit lo, bit rdy);
    vec_t t;
    t.e = e; t.v = v; t.d = d;
    t.hi = hi; t.lo = lo; t.rdy = rdy;
    tbl.push_back(t);
  endtask

  initial begin
    bit e;
    bit found;
    // N=4 from reset
    add(1,0,0, 1,1,1); add(1,0,0, 1,1,1);
    add(1,0,0, 0,0,1); add(1,0,0, 0,0,1);
    add(1,0,0, 1,1,1);
    // request 3 mid-period, 8 ignored while pending
    add(1,1,3, 1,1,0); add(1,1,8, 0,0,0);
    add(1,0,0, 0,0,0);
    add(1,0,0, 1,1,1); add(1,0,0, 1,0,1);
    add(1,0,0, 0,0,1); add(1,0,0, 1,1,1);
    // div 0 then 1 -> N=2
    add(1,1,0, 1,0,0); add(1,0,0, 0,0,0);
    add(1,0,0, 1,1,1); add(1,1,1, 0,0,0);
    add(1,0,0, 1,1,1); add(1,0,0, 0,0,1);
    // N=6, drop enable during high phase
    add(1,1,6, 1,1,0); add(1,0,0, 0,0,0);
    add(1,0,0, 1,1,1);
    add(0,0,0, 1,1,1); add(0,0,0, 1,1,1);
    add(0,0,0, 0,0,1); add(0,0,0, 0,0,1);
    add(0,0,0, 0,0,1); add(0,0,0, 0,0,1);
    add(0,0,0, 0,0,1);
    add(1,0,0, 1,1,1); add(1,0,0, 1,1,1);
    // 5 pending, 8 held off until the cycle after apply
    add(1,1,5, 1,1,0); add(1,1,8, 0,0,0);
    add(1,1,8, 0,0,0); add(1,1,8, 0,0,0);
    add(1,1,8, 1,1,1); add(1,1,8, 1,1,0);
    add(1,0,0, 1,0,0); add(1,0,0, 0,0,0);
    add(1,0,0, 0,0,0);
    add(1,0,0, 1,1,1); add(1,0,0, 1,1,1);
    add(1,0,0, 1,1,1); add(1,0,0, 1,1,1);
    add(1,0,0, 0,0,1);

    // reset state
    en = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst.clk", clk_o, 1'b0);
    chk("rst.rdy", div_ready, 1'b1);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      en = tbl[i].e;
      div_valid = tbl[i].v;
      div = W'(tbl[i].d);
      @(posedge clk);
      m_edge(tbl[i].e, tbl[i].v, tbl[i].d);
      #1;
      chk($sformatf("tbl%0d.hi", i + 1), clk_o, tbl[i].hi);
      chk($sformatf("tbl%0d.rdy", i + 1), div_ready, tbl[i].rdy);
      @(negedge clk);
      #1;
      chk($sformatf("tbl%0d.lo", i + 1), clk_o, tbl[i].lo);
    end

    // async reset during a high phase of N=10
    step(1, 1, 10, "n10req");
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1, 0, 0, "n10run");
      if (m_n == 10 && m_k == 1) found = 1;
    end
    chk("n10reach", found, 1'b1);
    chk("n10high", clk_o, 1'b1);
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("arst.clk", clk_o, 1'b0);
    chk("arst.rdy", div_ready, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step(1, 0, 0, "postrst");

    // randomized traffic against the model
    e = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) e = !e;
      step(e, ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 12)), "rnd");
    end

    // bypass
    rst_n = 1'b0;
    test_mode = 1'b1;
    #1;
    chk("tmode.rst", clk_o, clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("tmode.hi", clk_o, clk);
      @(negedge clk);
      #1;
      chk("tmode.lo", clk_o, clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
